aes_round_sequencer: RTL and testbench
======================================

# aes_round_sequencer

Iterative AES encryption controller that sequences one full cipher block through a shared, combinational round datapath (SubBytes, ShiftRows, optional MixColumns) and the AddRoundKey XOR. It owns the 128-bit state register and the round counter, and drives the key-schedule round index. It accepts blocks over a valid/ready handshake and returns each ciphertext over a second valid/ready handshake. It sits between the block-level I/O wrapper and the round/key-expansion datapath.

## Interface
- NR, 10, number of rounds (10/12/14 for AES-128/192/256); round counter is 4 bits wide.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  plaintext block valid.
- in_ready  out  1  sequencer can accept a block.
- in_data  in  128  plaintext, byte 0 in bits [127:120].
- key_round  out  4  round-key index requested from key schedule.
- key_in  in  128  round key for key_round, combinational, same cycle.
- rnd_in  out  128  current state presented to the round datapath.
- rnd_mix_en  out  1  enable MixColumns in the round datapath.
- rnd_out  in  128  round datapath result, combinational from rnd_in/rnd_mix_en.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  consumer accepts ciphertext.
- out_data  out  128  ciphertext, equal to the state register.
- busy  out  1  high in ROUND or DONE.

## Operation
- States: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1, key_round=0.
  - On in_valid: state <= in_data ^ key_in (initial AddRoundKey), rnd_cnt <= 1, go to ROUND.
- ROUND:
  - key_round=rnd_cnt, rnd_in=state, rnd_mix_en=(rnd_cnt != NR).
  - Each cycle: state <= rnd_out ^ key_in, rnd_cnt <= rnd_cnt+1.
  - When rnd_cnt==NR: go to DONE, and rnd_cnt returns to 0.
- DONE:
  - out_valid=1, out_data=state, held stable until out_ready.
  - On out_ready: go to IDLE.
- in_ready is high only in IDLE, so there is no overlap between blocks. in_valid in ROUND/DONE is ignored and must be held by the source.
- rnd_mix_en is 0 outside ROUND. rnd_in equals state in every state.
- Reset, including mid-operation: state=0, rnd_cnt=0, go to IDLE, in_ready=1, out_valid=0, busy=0, key_round=0. The partial block is discarded.

## Timing
- Accept edge is T0. ROUND covers cycles T1..T(NR). out_valid rises in cycle T(NR+1).
- Latency from accept to out_valid is NR+1 cycles (11 for NR=10).
- If out_ready is already high when out_valid rises, the transfer completes in that cycle and in_ready is 1 the next cycle.
- Minimum block period is NR+2 cycles (12 for NR=10).
- out_valid is never deasserted without out_ready. out_data does not change while out_valid=1.
- key_in and rnd_out are sampled only at clock edges. The combinational path is key_round/rnd_in -> key_in/rnd_out -> state D input.

## Structure
- Shared package aes_pkg holds:
  - NR_128=10, NR_192=12, NR_256=14.
  - Round-counter width constant (4).
  - State enum: IDLE=2'd0, ROUND=2'd1, DONE=2'd2.
- Sub-module: one instance of the existing AddRoundKey XOR block. Its input is muxed between in_data (IDLE) and rnd_out (ROUND).
- The FSM, counter and state register are flat in this module.

## Test plan
- Reset check:
  - Hold rst_n=0.
  - Required: in_ready=1, out_valid=0, busy=0, key_round=0, out_data=0.
- FIPS-197 Appendix B, NR=10, bench models the round datapath and key schedule:
  - Stimulus: in_data=3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c.
  - Required: out_data=3925841d02dc09fbdc118597196a0b32, out_valid exactly 11 cycles after accept.
  - Required: key_round steps 0,1..10; rnd_mix_en=1 for rounds 1–9 and 0 for round 10.
- FIPS-197 Appendix C.1:
  - Stimulus: in_data=00112233445566778899aabbccddeeff, key 000102…0f.
  - Required: out_data=69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid.
  - Required: out_data stable, in_ready=0, a second in_valid is not accepted.
  - Stimulus: then release out_ready.
  - Required: in_ready=1 the next cycle.
- Back-to-back:
  - Stimulus: in_valid and out_ready held high continuously.
  - Required: accepts spaced exactly 12 cycles apart, both ciphertexts correct.
- Reset mid-round:
  - Stimulus: assert rst_n=0 asynchronously at round 5.
  - Required: immediate IDLE outputs, no out_valid.
  - Stimulus: a following block.
  - Required: encrypts correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//   Shared constants and types for the iterative AES controller.
//   - NR_128 / NR_192 / NR_256 : round counts for the three AES key sizes
//   - CNT_W                    : width of the round counter
//   - seq_state_t              : sequencer FSM states
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  // Wide enough to count to 14, the largest round count.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/aes_add_round_key.sv
// ---------------------------------------------------------------------------
// aes_add_round_key
//   AddRoundKey step: bitwise XOR of a 128-bit block with a round key.
//   Ports:
//     block     in  128  data block
//     round_key in  128  round key
//     result    out 128  block ^ round_key
// ---------------------------------------------------------------------------
module aes_add_round_key (
  input  logic [127:0] block,
  input  logic [127:0] round_key,
  output logic [127:0] result
);

  assign result = block ^ round_key;

endmodule

// File: rtl/aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// aes_round_sequencer
//   Iterative AES encryption controller. Holds the 128-bit cipher state and
//   the round counter, walks one block through an external combinational
//   round datapath, and hands the ciphertext out over a valid/ready pair.
//   Ports:
//     clk, rst_n      clock (rising edge), async active-low reset
//     in_valid/ready  plaintext handshake, in_data is the plaintext block
//     key_round       round-key index requested from the key schedule
//     key_in          round key for key_round (combinational, same cycle)
//     rnd_in          cipher state presented to the round datapath
//     rnd_mix_en      MixColumns enable for the round datapath
//     rnd_out         round datapath result
//     out_valid/ready ciphertext handshake, out_data is the state register
//     busy            high while a block is in ROUND or DONE
// ---------------------------------------------------------------------------
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int NR = NR_128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic [CNT_W-1:0] key_round,
  input  logic [127:0]     key_in,
  output logic [127:0]     rnd_in,
  output logic             rnd_mix_en,
  input  logic [127:0]     rnd_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             busy
);

  localparam logic [CNT_W-1:0] NR_CNT = CNT_W'(NR);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [127:0]     data_q, data_d;
  logic [127:0]     ark_block;
  logic [127:0]     ark_result;

  // The single AddRoundKey XOR is shared: in IDLE it whitens the incoming
  // plaintext with round key 0, in ROUND it folds the round key into the
  // datapath result.
  assign ark_block = (state_q == IDLE) ? in_data : rnd_out;

  aes_add_round_key u_ark (
    .block     (ark_block),
    .round_key (key_in),
    .result    (ark_result)
  );

  // The state register always feeds both the round datapath and the
  // ciphertext output, so out_data is stable for as long as DONE holds.
  assign rnd_in   = data_q;
  assign out_data = data_q;
  assign busy     = (state_q != IDLE);

  // State, counter and cipher-state registers. Reset discards any block
  // in flight and returns to an empty IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Next-state and output decode. IDLE accepts a block and applies the
  // initial AddRoundKey; ROUND runs one full round per cycle with MixColumns
  // skipped on the last round; DONE holds the ciphertext until it is taken.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    key_round  = '0;
    rnd_mix_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = ark_result;
          cnt_d   = CNT_W'(1);
          state_d = ROUND;
        end
      end
      ROUND: begin
        key_round  = cnt_q;
        rnd_mix_en = (cnt_q != NR_CNT);
        data_d     = ark_result;
        if (cnt_q == NR_CNT) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aes_round_sequencer
//   Bench for the AES round sequencer. Models the combinational round
//   datapath and the AES-128 key schedule around the DUT, and compares the
//   ciphertext against a whole-block AES reference and FIPS-197 vectors.
// ---------------------------------------------------------------------------
module tb_aes_round_sequencer;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   key_round;
  logic [127:0] key_in;
  logic [127:0] rnd_in;
  logic         rnd_mix_en;
  logic [127:0] rnd_out;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  logic [1407:0] ks;
  int errors = 0;
  int checks = 0;

  aes_round_sequencer #(.NR(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .key_round  (key_round),
    .key_in     (key_in),
    .rnd_in     (rnd_in),
    .rnd_mix_en (rnd_mix_en),
    .rnd_out    (rnd_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GF(2^8) arithmetic with the AES polynomial.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] r = 8'h01;
    logic [7:0] p = b;
    logic [7:0] inv;
    int e = 254;
    while (e != 0) begin
      if (e % 2 == 1) r = gmul(r, p);
      p = gmul(p, p);
      e = e / 2;
    end
    inv = r;
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // SubBytes followed by ShiftRows; byte i is row i%4, column i/4.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o = '0;
    for (int i = 0; i < 16; i++) begin
      int r = i % 4;
      int c = i / 4;
      int src = r + 4 * ((c + r) % 4);
      o[127-8*i -: 8] = sbox(s[127-8*src -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o = '0;
    for (int c = 0; c < 4; c++) begin
      logic [7:0] a0, a1, a2, a3;
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  // AES-128 key expansion, round keys 0..10 packed high to low.
  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    logic [1407:0] o = '0;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) o[1407-32*i -: 32] = w[i];
    return o;
  endfunction

  // Whole-block AES-128 encryption reference.
  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [1407:0] k = expand(key);
    logic [127:0]  s = pt ^ k[1407 -: 128];
    for (int r = 1; r <= 10; r++) begin
      s = sub_shift(s);
      if (r != 10) s = mix(s);
      s = s ^ k[1407-128*r -: 128];
    end
    return s;
  endfunction

  // Environment around the DUT: key schedule lookup and round datapath.
  assign key_in  = (key_round <= 4'd10) ? ks[1407-128*int'(key_round) -: 128] : '0;
  assign rnd_out = rnd_mix_en ? mix(sub_shift(rnd_in)) : sub_shift(rnd_in);

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one block, wait for its ciphertext and optionally check the
  // round index / MixColumns sequence. Returns at the first negedge with
  // out_valid high (or after the cycle budget runs out).
  task automatic apply_stimulus(input logic [127:0] pt, input logic [127:0] key, input bit check_seq);
    int cyc;
    ks       = expand(key);
    in_data  = pt;
    in_valid = 1'b1;
    check_output("idle_key_round", key_round, 0);
    check_output("idle_in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    if (check_seq) check_output("busy_round", busy, 1);
    while (out_valid !== 1'b1 && cyc < 40) begin
      if (check_seq) begin
        check_output($sformatf("key_round_%0d", cyc), key_round, cyc);
        check_output($sformatf("mix_en_%0d", cyc), rnd_mix_en, (cyc != 10));
      end
      @(negedge clk);
      cyc++;
    end
    check_output("latency", cyc, 11);
    check_output("cipher_ref", out_data, aes_ref(pt, key));
  endtask

  // Take the ciphertext and confirm the sequencer is ready again.
  task automatic drain_output();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_output("ready_after_take", in_ready, 1);
    check_output("valid_after_take", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [127:0] key, pt, held;
    int accepts [$];
    logic [127:0] exp_q [$];
    bit accepted;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    ks        = expand(128'h0);

    // Reset state.
    repeat (3) @(negedge clk);
    check_output("rst_in_ready", in_ready, 1);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_key_round", key_round, 0);
    check_output("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 Appendix B with full round-sequence checking.
    $display("[TB] FIPS-197 appendix B");
    apply_stimulus(128'h3243f6a8885a308d313198a2e0370734,
                   128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1);
    check_output("fips_b", out_data, 128'h3925841d02dc09fbdc118597196a0b32);
    drain_output();

    // FIPS-197 Appendix C.1, then backpressure for 5 cycles with a second
    // block waiting on the input side.
    $display("[TB] FIPS-197 appendix C.1 with backpressure");
    apply_stimulus(128'h00112233445566778899aabbccddeeff,
                   128'h000102030405060708090a0b0c0d0e0f, 1'b0);
    check_output("fips_c1", out_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    held     = out_data;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("bp_out_data", out_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      check_output("bp_in_ready", in_ready, 0);
      check_output("bp_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_output("bp_ready_after", in_ready, 1);
    check_output("bp_busy_after", busy, 0);

    // Random blocks under random keys.
    $display("[TB] random blocks");
    for (int n = 0; n < 3; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      apply_stimulus(pt, key, 1'b0);
      drain_output();
    end

    // Back-to-back: in_valid and out_ready held high.
    $display("[TB] back-to-back");
    key = {$urandom, $urandom, $urandom, $urandom};
    ks  = expand(key);
    in_data   = {$urandom, $urandom, $urandom, $urandom};
    in_valid  = 1'b1;
    out_ready = 1'b1;
    accepted  = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) check_output("b2b_unexpected_out", out_valid, 0);
        else check_output("b2b_cipher", out_data, exp_q.pop_front());
      end
      if (in_ready === 1'b1) begin
        accepts.push_back(cyc);
        exp_q.push_back(aes_ref(in_data, key));
        accepted = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      if (accepted) begin
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        accepted = 1'b0;
      end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 20 && out_valid !== 1'b1; k++) @(negedge clk);
    check_output("b2b_last_valid", out_valid, 1);
    if (exp_q.size() != 0) check_output("b2b_last_cipher", out_data, exp_q.pop_front());
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_output("b2b_accepts", accepts.size(), 3);
    if (accepts.size() >= 3) begin
      check_output("b2b_gap1", accepts[1] - accepts[0], 12);
      check_output("b2b_gap2", accepts[2] - accepts[1], 12);
    end
    check_output("b2b_queue_empty", exp_q.size(), 0);

    // Asynchronous reset in the middle of round 5.
    $display("[TB] reset mid-round");
    key = {$urandom, $urandom, $urandom, $urandom};
    ks  = expand(key);
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_output("mid_key_round", key_round, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_in_ready", in_ready, 1);
    check_output("mid_rst_out_valid", out_valid, 0);
    check_output("mid_rst_busy", busy, 0);
    check_output("mid_rst_key_round", key_round, 0);
    check_output("mid_rst_mix_en", rnd_mix_en, 0);
    check_output("mid_rst_out_data", out_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_output("mid_no_out_valid", out_valid, 0);
    end
    pt = {$urandom, $urandom, $urandom, $urandom};
    apply_stimulus(pt, key, 1'b1);
    drain_output();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
